brew_scheduler: RTL and testbench

BREW_SCHEDULER -- requirements
Module: brew_scheduler

---
 rtl/coffee_pkg.sv | 47 ++++
 rtl/rr_arbiter3.sv | 34 +++
 rtl/brew_scheduler.sv | 153 +++++++++++++++
 tb/tb_brew_scheduler.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/coffee_pkg.sv
// Shared state encodings, drink codes and milk costs for the brew scheduler.
package coffee_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GRANT = 3'd1,
    ST_BREW  = 3'd2,
    ST_CLEAN = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

  localparam logic [1:0] DRINK_BLACK      = 2'b00;
  localparam logic [1:0] DRINK_LATTE      = 2'b01;
  localparam logic [1:0] DRINK_CAPPUCCINO = 2'b10;
  localparam logic [1:0] DRINK_INVALID    = 2'b11;

  localparam logic [3:0] COST_BLACK      = 4'd0;
  localparam logic [3:0] COST_LATTE      = 4'd1;
  localparam logic [3:0] COST_CAPPUCCINO = 4'd2;

  localparam int MILK_MAX_DEFAULT = 15;

  // Invalid drinks are refused before any cost is charged, so their cost is moot.
  function automatic logic [3:0] milk_cost(input logic [1:0] drink);
    logic [3:0] cost;
    case (drink)
      DRINK_BLACK:      cost = COST_BLACK;
      DRINK_LATTE:      cost = COST_LATTE;
      DRINK_CAPPUCCINO: cost = COST_CAPPUCCINO;
      default:          cost = COST_BLACK;
    endcase
    return cost;
  endfunction

  function automatic logic [1:0] onehot_to_idx(input logic [2:0] oh);
    logic [1:0] idx;
    if (oh[2])      idx = 2'd2;
    else if (oh[1]) idx = 2'd1;
    else            idx = 2'd0;
    return idx;
  endfunction

  function automatic logic [1:0] next_panel(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Combinational 3-way round-robin pick: the first asserted request at or after ptr wins.
module rr_arbiter3 (
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic [2:0] pick,
  output logic       valid
);

  logic [2:0] rot;
  logic [2:0] prio;

  always_comb begin
    // Rotate so bit 0 is the panel the pointer names, pick lowest, rotate back.
    case (ptr)
      2'd1:    rot = {req[0], req[2], req[1]};
      2'd2:    rot = {req[1], req[0], req[2]};
      default: rot = req;
    endcase

    prio = 3'b000;
    if (rot[0])      prio = 3'b001;
    else if (rot[1]) prio = 3'b010;
    else if (rot[2]) prio = 3'b100;

    case (ptr)
      2'd1:    pick = {prio[1], prio[0], prio[2]};
      2'd2:    pick = {prio[0], prio[2], prio[1]};
      default: pick = prio;
    endcase

    valid = |req;
  end

endmodule

// File: rtl/brew_scheduler.sv
// Schedules one shared brewer among three order panels, tracking milk stock,
// a brew watchdog and a post-drink flush period.
module brew_scheduler
  import coffee_pkg::*;
#(
  parameter int CLEAN_CYCLES = 4,
  parameter int BREW_TIMEOUT = 15,
  parameter int MILK_MAX     = MILK_MAX_DEFAULT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] req,
  input  logic [5:0] drink_sel,
  output logic [2:0] gnt,
  output logic [2:0] reject,
  output logic       brew_start,
  output logic [1:0] brew_type,
  input  logic       brew_done,
  input  logic       milk_refill,
  output logic [3:0] milk_level,
  output logic       busy,
  output logic       fault,
  input  logic       fault_clr
);

  localparam int TMAX = (BREW_TIMEOUT > CLEAN_CYCLES) ? BREW_TIMEOUT : CLEAN_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  state_t          state_reg, state_next;
  logic [1:0]      ptr_reg, ptr_next;
  logic [1:0]      owner_reg, owner_next;
  logic [1:0]      drink_reg, drink_next;
  logic [TW-1:0]   timer_reg, timer_next;
  logic [3:0]      milk_reg, milk_next;

  logic [2:0] pick_oh;
  logic       pick_valid;
  logic [1:0] pick_idx;
  logic [1:0] pick_drink;
  logic       pick_bad;
  logic [2:0] reject_raw;
  logic       owns_brewer;
  logic [1:0] panel_drink [3];

  rr_arbiter3 u_arb (
    .req   (req),
    .ptr   (ptr_reg),
    .pick  (pick_oh),
    .valid (pick_valid)
  );

  assign owns_brewer = (state_reg == ST_GRANT) || (state_reg == ST_BREW);

  for (genvar gi = 0; gi < 3; gi++) begin : g_panel
    assign panel_drink[gi] = drink_sel[2*gi +: 2];
    assign gnt[gi]         = owns_brewer && (owner_reg == 2'(gi));
  end

  assign pick_idx = onehot_to_idx(pick_oh);

  always_comb begin
    case (pick_idx)
      2'd1:    pick_drink = panel_drink[1];
      2'd2:    pick_drink = panel_drink[2];
      default: pick_drink = panel_drink[0];
    endcase
  end

  assign pick_bad = (pick_drink == DRINK_INVALID) || (milk_cost(pick_drink) > milk_reg);

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    owner_next = owner_reg;
    drink_next = drink_reg;
    timer_next = timer_reg;
    milk_next  = milk_refill ? 4'(MILK_MAX) : milk_reg;
    reject_raw = 3'b000;

    case (state_reg)
      ST_IDLE: begin
        if (pick_valid) begin
          ptr_next = next_panel(pick_idx);
          if (pick_bad) begin
            reject_raw = pick_oh;
          end else begin
            state_next = ST_GRANT;
            owner_next = pick_idx;
            drink_next = pick_drink;
          end
        end
      end
      ST_GRANT: begin
        // A refill in this same cycle still pays for the drink being started.
        milk_next  = milk_next - milk_cost(drink_reg);
        timer_next = '0;
        state_next = ST_BREW;
      end
      ST_BREW: begin
        if (brew_done) begin
          state_next = ST_CLEAN;
          timer_next = '0;
        end else if (timer_reg == TW'(BREW_TIMEOUT - 1)) begin
          state_next = ST_FAULT;
        end else begin
          timer_next = timer_reg + TW'(1);
        end
      end
      ST_CLEAN: begin
        if (timer_reg == TW'(CLEAN_CYCLES - 1)) begin
          state_next = ST_IDLE;
          timer_next = '0;
        end else begin
          timer_next = timer_reg + TW'(1);
        end
      end
      ST_FAULT: begin
        if (fault_clr) begin
          state_next = ST_IDLE;
          timer_next = '0;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
      ptr_reg   <= 2'd0;
      owner_reg <= 2'd0;
      drink_reg <= DRINK_BLACK;
      timer_reg <= '0;
      milk_reg  <= 4'd0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      owner_reg <= owner_next;
      drink_reg <= drink_next;
      timer_reg <= timer_next;
      milk_reg  <= milk_next;
    end
  end

  // Reject is decoded from live requests, so it must be masked while reset is held.
  assign reject     = reset_n ? reject_raw : 3'b000;
  assign brew_start = (state_reg == ST_GRANT);
  assign brew_type  = owns_brewer ? drink_reg : DRINK_BLACK;
  assign busy       = (state_reg != ST_IDLE);
  assign fault      = (state_reg == ST_FAULT);
  assign milk_level = milk_reg;

endmodule

// File: tb/tb_brew_scheduler.sv
// Directed bench for brew_scheduler: reset, grant flow, round-robin, rejects,
// watchdog fault, milk accounting and mid-brew reset.
module tb_brew_scheduler;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [2:0] req = 3'b000;
  logic [5:0] drink_sel = 6'b000000;
  logic       brew_done = 1'b0;
  logic       milk_refill = 1'b0;
  logic       fault_clr = 1'b0;
  logic [2:0] gnt;
  logic [2:0] reject;
  logic       brew_start;
  logic [1:0] brew_type;
  logic [3:0] milk_level;
  logic       busy;
  logic       fault;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  brew_scheduler dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req         (req),
    .drink_sel   (drink_sel),
    .gnt         (gnt),
    .reject      (reject),
    .brew_start  (brew_start),
    .brew_type   (brew_type),
    .brew_done   (brew_done),
    .milk_refill (milk_refill),
    .milk_level  (milk_level),
    .busy        (busy),
    .fault       (fault),
    .fault_clr   (fault_clr)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    req = 3'b000; drink_sel = 6'b000000; brew_done = 1'b0;
    milk_refill = 1'b0; fault_clr = 1'b0;
    reset_n = 1'b0;
    step; step;
    reset_n = 1'b1;
  endtask

  task automatic test_reset;
    req = 3'b111; drink_sel = 6'b101010;
    #2; reset_n = 1'b0;
    step; step;
    @(negedge clk);
    checks++; if ({gnt, reject} !== 6'b000000) begin errors++; $display("FAIL reset_gnt_reject got=%b exp=000000", {gnt, reject}); end
    checks++; if ({brew_start, busy, fault} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {brew_start, busy, fault}); end
    checks++; if (milk_level !== 4'd0) begin errors++; $display("FAIL reset_milk got=%0d exp=0", milk_level); end
    checks++; if (brew_type !== 2'b00) begin errors++; $display("FAIL reset_brew_type got=%b exp=00", brew_type); end
    req = 3'b000; drink_sel = 6'b000000;
    step;
    reset_n = 1'b1;
    $display("test_reset: outputs held low in reset");
  endtask

  task automatic test_basic;
    milk_refill = 1'b1; step; milk_refill = 1'b0;
    req = 3'b001; drink_sel = 6'b000001;
    @(negedge clk);
    checks++; if (milk_level !== 4'd15) begin errors++; $display("FAIL basic_refill got=%0d exp=15", milk_level); end
    checks++; if ({reject, brew_start} !== 4'b0000) begin errors++; $display("FAIL basic_pick_cycle got=%b exp=0000", {reject, brew_start}); end
    step; req = 3'b000;
    @(negedge clk);
    checks++; if ({gnt, brew_start, brew_type, busy} !== 7'b0011011) begin errors++; $display("FAIL basic_grant got=%b exp=0011011", {gnt, brew_start, brew_type, busy}); end
    step;
    @(negedge clk);
    checks++; if ({gnt, brew_start, brew_type} !== 6'b001001) begin errors++; $display("FAIL basic_brew got=%b exp=001001", {gnt, brew_start, brew_type}); end
    checks++; if (milk_level !== 4'd14) begin errors++; $display("FAIL basic_milk got=%0d exp=14", milk_level); end
    brew_done = 1'b1; step; brew_done = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++; if ({gnt, busy} !== 4'b0001) begin errors++; $display("FAIL basic_clean%0d got=%b exp=0001", k, {gnt, busy}); end
      step;
    end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle_after_clean got=%b exp=0", busy); end
    step;
    $display("test_basic: panel 0 latte brewed, milk 15->14");
  endtask

  task automatic test_round_robin;
    logic [2:0] exp_gnt;
    do_reset;
    req = 3'b111; drink_sel = 6'b000000;
    for (int n = 0; n < 4; n++) begin
      exp_gnt = 3'(1 << (n % 3));
      step;
      @(negedge clk);
      checks++; if ({gnt, brew_start} !== {exp_gnt, 1'b1}) begin errors++; $display("FAIL rr_grant%0d got=%b exp=%b", n, {gnt, brew_start}, {exp_gnt, 1'b1}); end
      step;
      brew_done = 1'b1; step; brew_done = 1'b0;
      repeat (4) step;
      $display("test_round_robin: grant %0d gnt=%b", n, gnt);
    end
    req = 3'b000;
  endtask

  task automatic test_reject;
    do_reset;
    req = 3'b110; drink_sel = 6'b001000;
    @(negedge clk);
    checks++; if (reject !== 3'b010) begin errors++; $display("FAIL rej_pulse got=%b exp=010", reject); end
    checks++; if ({brew_start, busy} !== 2'b00) begin errors++; $display("FAIL rej_no_start got=%b exp=00", {brew_start, busy}); end
    step; req = 3'b100;
    @(negedge clk);
    checks++; if (reject !== 3'b000) begin errors++; $display("FAIL rej_one_cycle got=%b exp=000", reject); end
    step;
    @(negedge clk);
    checks++; if ({gnt, brew_start, brew_type} !== 6'b100100) begin errors++; $display("FAIL rej_next_grant got=%b exp=100100", {gnt, brew_start, brew_type}); end
    req = 3'b000;
    step;
    brew_done = 1'b1; step; brew_done = 1'b0;
    repeat (4) step;
    $display("test_reject: panel 1 refused, panel 2 granted");
  endtask

  task automatic test_fault;
    req = 3'b001; drink_sel = 6'b000000;
    step; req = 3'b000;
    @(negedge clk);
    checks++; if ({gnt, brew_start} !== 4'b0011) begin errors++; $display("FAIL fault_grant got=%b exp=0011", {gnt, brew_start}); end
    step;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      checks++; if ({fault, gnt} !== 4'b0001) begin errors++; $display("FAIL fault_brew%0d got=%b exp=0001", k, {fault, gnt}); end
      step;
    end
    @(negedge clk);
    checks++; if ({fault, gnt, busy} !== 5'b10001) begin errors++; $display("FAIL fault_enter got=%b exp=10001", {fault, gnt, busy}); end
    req = 3'b010; brew_done = 1'b1;
    step; brew_done = 1'b0;
    @(negedge clk);
    checks++; if ({fault, reject, gnt} !== 7'b1000000) begin errors++; $display("FAIL fault_hold got=%b exp=1000000", {fault, reject, gnt}); end
    fault_clr = 1'b1; req = 3'b000;
    step; fault_clr = 1'b0;
    @(negedge clk);
    checks++; if ({fault, busy} !== 2'b00) begin errors++; $display("FAIL fault_clear got=%b exp=00", {fault, busy}); end
    checks++; if (milk_level !== 4'd0) begin errors++; $display("FAIL fault_milk got=%0d exp=0", milk_level); end
    brew_done = 1'b1; step; brew_done = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_done_ignored got=%b exp=0", busy); end
    step;
    $display("test_fault: watchdog tripped and cleared");
  endtask

  task automatic test_refill_grant;
    milk_refill = 1'b1; step; milk_refill = 1'b0;
    drink_sel = 6'b000010;
    for (int n = 0; n < 6; n++) begin
      req = 3'b001; step; req = 3'b000; step;
      brew_done = 1'b1; step; brew_done = 1'b0;
      repeat (4) step;
    end
    @(negedge clk);
    checks++; if (milk_level !== 4'd3) begin errors++; $display("FAIL refill_pre got=%0d exp=3", milk_level); end
    step;
    req = 3'b001; drink_sel = 6'b000001;
    step; req = 3'b000; milk_refill = 1'b1;
    step; milk_refill = 1'b0;
    @(negedge clk);
    checks++; if (milk_level !== 4'd14) begin errors++; $display("FAIL refill_coincident got=%0d exp=14", milk_level); end
    checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL refill_brew_gnt got=%b exp=001", gnt); end
    brew_done = 1'b1; step; brew_done = 1'b0;
    repeat (4) step;
    req = 3'b010; drink_sel = 6'b001100;
    @(negedge clk);
    checks++; if (reject !== 3'b010) begin errors++; $display("FAIL invalid_drink got=%b exp=010", reject); end
    step; req = 3'b000;
    @(negedge clk);
    checks++; if ({busy, reject} !== 4'b0000) begin errors++; $display("FAIL invalid_after got=%b exp=0000", {busy, reject}); end
    step;
    $display("test_refill_grant: milk 3 + refill at grant -> %0d", milk_level);
  endtask

  task automatic test_reset_mid_brew;
    req = 3'b001; drink_sel = 6'b000000;
    step; req = 3'b000; step;
    @(negedge clk);
    checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL midrst_pre got=%b exp=001", gnt); end
    step;
    reset_n = 1'b0;
    #1;
    checks++; if ({gnt, reject, brew_start, brew_type, busy, fault} !== 11'b0) begin errors++; $display("FAIL midrst_outputs got=%b exp=0", {gnt, reject, brew_start, brew_type, busy, fault}); end
    checks++; if (milk_level !== 4'd0) begin errors++; $display("FAIL midrst_milk got=%0d exp=0", milk_level); end
    step; step;
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if ({brew_start, reject, gnt, busy} !== 8'b0) begin errors++; $display("FAIL midrst_release%0d got=%b exp=0", k, {brew_start, reject, gnt, busy}); end
      step;
    end
    $display("test_reset_mid_brew: brew abandoned cleanly");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_basic;
    test_round_robin;
    test_reject;
    test_fault;
    test_refill_grant;
    test_reset_mid_brew;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
